// File: rtl/jtag_uart_pkg.sv
// Shared constants and FSM state type for the jtag_uart stream bridge.
package jtag_uart_pkg;

  localparam logic        JU_ADDR_DATA  = 1'b0;
  localparam logic        JU_ADDR_CTRL  = 1'b1;
  localparam int unsigned JU_RVALID_BIT = 15;
  localparam int unsigned JU_WSPACE_LSB = 16;
  localparam int unsigned JU_DATA_W     = 32;
  localparam int unsigned JU_BYTE_W     = 8;
  localparam int unsigned JU_STAT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_DATA = 2'd1,
    ST_RD_CTRL = 2'd2,
    ST_WR_DATA = 2'd3
  } ju_state_e;

endpackage

// File: rtl/jtag_uart_stream_bridge_if.sv
// Avalon-MM bus between the bridge (master) and the jtag_uart slave port.
interface jtag_uart_stream_bridge_if;
  import jtag_uart_pkg::*;

  logic                 chipselect;
  logic                 address;
  logic                 read_n;
  logic                 write_n;
  logic [JU_DATA_W-1:0] writedata;
  logic [JU_DATA_W-1:0] readdata;
  logic                 waitrequest;

  modport master (
    output chipselect, address, read_n, write_n, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, address, read_n, write_n, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/jtag_uart_backoff_cnt.sv
// Loadable down-counter that stops at zero; used as a re-poll backoff timer.
module jtag_uart_backoff_cnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/jtag_uart_stream_bridge.sv
// Bridges 8-bit tx/rx valid/ready streams onto the jtag_uart Avalon-MM slave port.
// Optional byte counters are enabled with `define JTAG_UART_BRIDGE_STATS_EN.
module jtag_uart_stream_bridge
  import jtag_uart_pkg::*;
#(
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned TX_CREDIT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [JU_BYTE_W-1:0]        tx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [JU_BYTE_W-1:0]        rx_data,
  jtag_uart_stream_bridge_if.master   avm,
  output logic [JU_STAT_W-1:0]        rx_byte_cnt,
  output logic [JU_STAT_W-1:0]        tx_byte_cnt
);

  localparam int unsigned BO_W     = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
  localparam int unsigned WSPACE_W = JU_DATA_W - JU_WSPACE_LSB;

  ju_state_e              state_q, state_d;
  logic                   last_rx_q;
  logic [TX_CREDIT_W-1:0] credit_q;
  logic [TX_CREDIT_W-1:0] wspace_sat;
  logic [WSPACE_W-1:0]    wspace;
  logic [BO_W-1:0]        rx_bo, tx_bo;
  logic                   rx_bo_load, tx_bo_load;
  logic                   rx_elig, tx_elig, pick_rx;
  logic                   done_c, rvalid, wspace_zero;
  logic                   cs_d, addr_d, rd_n_d, wr_n_d;
  logic [JU_DATA_W-1:0]   wdata_d;
  logic                   unused_rd;

  assign done_c      = (state_q != ST_IDLE) && !avm.waitrequest;
  assign rvalid      = avm.readdata[JU_RVALID_BIT];
  assign wspace      = avm.readdata[JU_WSPACE_LSB +: WSPACE_W];
  assign wspace_zero = (wspace == '0);
  assign unused_rd   = ^avm.readdata[JU_RVALID_BIT-1:JU_BYTE_W];

  assign rx_elig = !rx_valid && (rx_bo == '0);
  assign tx_elig = tx_valid && (tx_bo == '0);
  // On a tie, alternate: rx wins unless rx was the last side served.
  assign pick_rx = rx_elig && (!tx_elig || !last_rx_q);

  // WSPACE clamped to what the credit counter can hold.
  if (TX_CREDIT_W >= WSPACE_W) begin : g_credit_wide
    assign wspace_sat = TX_CREDIT_W'(wspace);
  end else begin : g_credit_narrow
    assign wspace_sat = (|wspace[WSPACE_W-1:TX_CREDIT_W]) ? '1 : wspace[TX_CREDIT_W-1:0];
  end

  jtag_uart_backoff_cnt #(.W(BO_W)) u_rx_backoff (
    .clk      (clk),
    .reset    (reset),
    .load     (rx_bo_load),
    .load_val (BO_W'(POLL_GAP)),
    .cnt      (rx_bo)
  );

  jtag_uart_backoff_cnt #(.W(BO_W)) u_tx_backoff (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_bo_load),
    .load_val (BO_W'(POLL_GAP)),
    .cnt      (tx_bo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_rx)      state_d = ST_RD_DATA;
        else if (tx_elig) state_d = (credit_q != '0) ? ST_WR_DATA : ST_RD_CTRL;
      end
      default: begin
        if (!avm.waitrequest) state_d = ST_IDLE;
      end
    endcase
  end

  // Bus next-values: loaded on leaving IDLE, held while stalled, idled after completion.
  always_comb begin
    cs_d       = avm.chipselect;
    addr_d     = avm.address;
    rd_n_d     = avm.read_n;
    wr_n_d     = avm.write_n;
    wdata_d    = avm.writedata;
    tx_ready   = 1'b0;
    rx_bo_load = 1'b0;
    tx_bo_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (state_d != ST_IDLE) begin
          cs_d    = 1'b1;
          addr_d  = (state_d == ST_RD_CTRL) ? JU_ADDR_CTRL : JU_ADDR_DATA;
          rd_n_d  = (state_d == ST_WR_DATA);
          wr_n_d  = (state_d != ST_WR_DATA);
          wdata_d = (state_d == ST_WR_DATA) ? JU_DATA_W'(tx_data) : '0;
        end
      end
      ST_RD_DATA: rx_bo_load = done_c && !rvalid;
      ST_RD_CTRL: tx_bo_load = done_c && wspace_zero;
      ST_WR_DATA: tx_ready   = done_c;
      default: ;
    endcase
    if (done_c) begin
      cs_d    = 1'b0;
      addr_d  = JU_ADDR_DATA;
      rd_n_d  = 1'b1;
      wr_n_d  = 1'b1;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm.chipselect <= 1'b0;
      avm.address    <= JU_ADDR_DATA;
      avm.read_n     <= 1'b1;
      avm.write_n    <= 1'b1;
      avm.writedata  <= '0;
    end else begin
      avm.chipselect <= cs_d;
      avm.address    <= addr_d;
      avm.read_n     <= rd_n_d;
      avm.write_n    <= wr_n_d;
      avm.writedata  <= wdata_d;
    end
  end

  // rx holding register, tx credit and arbitration history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      credit_q  <= '0;
      last_rx_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && state_d != ST_IDLE) last_rx_q <= (state_d == ST_RD_DATA);
      if (state_q == ST_RD_DATA && done_c && rvalid) begin
        rx_valid <= 1'b1;
        rx_data  <= avm.readdata[JU_BYTE_W-1:0];
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (state_q == ST_RD_CTRL && done_c)      credit_q <= wspace_sat;
      else if (state_q == ST_WR_DATA && done_c) credit_q <= credit_q - TX_CREDIT_W'(1);
    end
  end

`ifdef JTAG_UART_BRIDGE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte_cnt <= '0;
      tx_byte_cnt <= '0;
    end else begin
      if (state_q == ST_RD_DATA && done_c && rvalid) rx_byte_cnt <= rx_byte_cnt + JU_STAT_W'(1);
      if (state_q == ST_WR_DATA && done_c)           tx_byte_cnt <= tx_byte_cnt + JU_STAT_W'(1);
    end
  end
`else
  assign rx_byte_cnt = '0;
  assign tx_byte_cnt = '0;
`endif

endmodule

// File: tb/tb_jtag_uart_stream_bridge.sv
// Directed bench for jtag_uart_stream_bridge with a small jtag_uart slave model.
module tb_jtag_uart_stream_bridge;
  import jtag_uart_pkg::*;

  logic        clk, reset;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0]  tx_data, rx_data;
  logic [15:0] rx_byte_cnt, tx_byte_cnt;

  jtag_uart_stream_bridge_if avm ();

  jtag_uart_stream_bridge #(.POLL_GAP(16), .TX_CREDIT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .avm         (avm),
    .rx_byte_cnt (rx_byte_cnt),
    .tx_byte_cnt (tx_byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: stalls each transaction stall_n cycles, DATA returns one pending byte.
  int          stall_n  = 0;
  int          wait_ctr = 0;
  logic        rx_avail = 1'b0;
  logic [7:0]  rx_byte  = 8'h00;
  logic [15:0] wspace   = 16'd16;

  always_comb begin
    avm.waitrequest = avm.chipselect && (wait_ctr < stall_n);
    avm.readdata    = avm.address ? {wspace, 16'h0102} : {16'h0000, rx_avail, 7'h00, rx_byte};
  end

  always @(posedge clk) begin
    if (!avm.chipselect)     wait_ctr <= 0;
    else if (avm.waitrequest) wait_ctr <= wait_ctr + 1;
  end

  // Bus monitor, sampled 1ns after the falling edge.
  int cyc = 0, writes = 0, ctrl_rd = 0, data_rd = 0, data_starts = 0, rx_ok = 0;
  int ready_pulses = 0, ready_bad = 0, bus_bad = 0;
  int wr_run = 0, last_wr_run = 0, ctrl_gap = 0, data_gap = 0;
  int ctrl_done_cyc = 0, data_done_cyc = 0, wr_since_rst = 0, rx_since_rst = 0;
  bit run_unstable = 0, last_ctrl_empty = 0, last_data_empty = 0;
  bit prev_cs = 0, mon_start, mon_done;
  logic [31:0] run_wd = '0;
  logic [31:0] wr_log[$];

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (reset) begin
      wr_since_rst = 0;
      rx_since_rst = 0;
    end else begin
      mon_start = avm.chipselect && !prev_cs;
      mon_done  = avm.chipselect && !avm.waitrequest;
      if (!avm.read_n && !avm.write_n) bus_bad++;
      if (tx_ready) begin
        ready_pulses++;
        if (!(mon_done && !avm.write_n)) ready_bad++;
      end
      if (avm.chipselect && !avm.write_n) begin
        if (mon_start) begin
          run_wd = avm.writedata;
          wr_run = 0;
          run_unstable = 0;
        end
        wr_run++;
        if (avm.writedata !== run_wd || avm.address !== JU_ADDR_DATA || !avm.read_n) run_unstable = 1;
        if (mon_done) begin
          last_wr_run = wr_run;
          writes++;
          wr_since_rst++;
          wr_log.push_back(avm.writedata);
        end
      end
      if (avm.chipselect && !avm.read_n && avm.address == JU_ADDR_CTRL) begin
        if (mon_start && last_ctrl_empty) ctrl_gap = cyc - ctrl_done_cyc;
        if (mon_done) begin
          ctrl_rd++;
          ctrl_done_cyc = cyc;
          last_ctrl_empty = (wspace == 16'd0);
        end
      end
      if (avm.chipselect && !avm.read_n && avm.address == JU_ADDR_DATA) begin
        if (mon_start) begin
          data_starts++;
          if (last_data_empty) data_gap = cyc - data_done_cyc;
        end
        if (mon_done) begin
          data_rd++;
          data_done_cyc = cyc;
          last_data_empty = !rx_avail;
          if (rx_avail) begin
            rx_ok++;
            rx_since_rst++;
          end
        end
      end
    end
    prev_cs = avm.chipselect;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    tx_valid = 1'b1;
    tx_data  = b;
    n = 0;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("tx_handshake", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, n;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs",      32'(avm.chipselect), 32'd0);
    check("rst_read_n",  32'(avm.read_n),     32'd1);
    check("rst_write_n", 32'(avm.write_n),    32'd1);
    check("rst_address", 32'(avm.address),    32'd0);
    check("rst_wdata",   avm.writedata,       32'd0);
    check("rst_rx_valid",32'(rx_valid),       32'd0);
    check("rst_rx_data", 32'(rx_data),        32'd0);
    check("rst_tx_ready",32'(tx_ready),       32'd0);
    check("rst_credit",  32'(dut.credit_q),   32'd0);
    reset = 1'b0;

    // Credit fetch then three writes.
    t0 = ctrl_rd; t1 = writes; t2 = ready_pulses;
    wr_log.delete();
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    check("t1_ctrl_reads", 32'(ctrl_rd - t0),      32'd1);
    check("t1_writes",     32'(writes - t1),       32'd3);
    check("t1_ready",      32'(ready_pulses - t2), 32'd3);
    check("t1_wd0",        wr_log[0],              32'h41);
    check("t1_wd1",        wr_log[1],              32'h42);
    check("t1_wd2",        wr_log[2],              32'h43);
    check("t1_credit",     32'(dut.credit_q),      32'd13);

    // Write stalled by waitrequest for 5 cycles.
    stall_n = 5; t1 = writes; t2 = ready_pulses;
    send_byte(8'h5A);
    stall_n = 0;
    check("t5_write_len",  32'(last_wr_run),       32'd6);
    check("t5_stable",     32'(run_unstable),      32'd0);
    check("t5_ready",      32'(ready_pulses - t2), 32'd1);
    check("t5_ready_done", 32'(ready_bad),         32'd0);
    check("t5_wdata",      wr_log[$],              32'h5A);
    check("t5_credit",     32'(dut.credit_q),      32'd12);

    // rx byte held while downstream stalls.
    rx_byte = 8'h55; rx_avail = 1'b1; t0 = rx_ok;
    n = 0;
    while (!rx_valid && n < 200) begin @(negedge clk); n++; end
    rx_avail = 1'b0;
    check("t2_rx_valid", 32'(rx_valid), 32'd1);
    check("t2_rx_data",  32'(rx_data),  32'h55);
    t1 = data_starts;
    repeat (10) @(negedge clk);
    check("t2_hold_valid", 32'(rx_valid),          32'd1);
    check("t2_hold_data",  32'(rx_data),           32'h55);
    check("t2_no_poll",    32'(data_starts - t1),  32'd0);
    check("t2_rx_reads",   32'(rx_ok - t0),        32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("t2_rx_clear", 32'(rx_valid), 32'd0);

    // Empty DATA read backs off before the next poll.
    t0 = data_starts; n = 0;
    while (data_starts < t0 + 2 && n < 200) begin @(negedge clk); n++; end
    check("t3_polls", 32'(data_starts - t0 >= 2), 32'd1);
    check("t3_gap",   32'(data_gap),              32'd18);

    // Asynchronous reset in the middle of a stalled DATA read.
    stall_n = 1000; n = 0;
    while (!(avm.chipselect && !avm.read_n && avm.address == JU_ADDR_DATA) && n < 200) begin
      @(negedge clk); n++;
    end
    check("t6_in_rd", 32'(avm.chipselect && !avm.read_n), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1; wspace = 16'd0;
    #1;
    check("t6_cs",       32'(avm.chipselect),  32'd0);
    check("t6_read_n",   32'(avm.read_n),      32'd1);
    check("t6_write_n",  32'(avm.write_n),     32'd1);
    check("t6_address",  32'(avm.address),     32'd0);
    check("t6_rx_valid", 32'(rx_valid),        32'd0);
    check("t6_tx_ready", 32'(tx_ready),        32'd0);
    check("t6_state",    32'(dut.state_q),     32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0; stall_n = 0; t0 = data_rd; n = 0;
    while (data_rd == t0 && n < 200) begin @(negedge clk); n++; end
    check("t6_resume", 32'(data_rd - t0 >= 1), 32'd1);

    // No credit: CTRL polled with backoff, write only once WSPACE=1.
    t0 = ctrl_rd; t1 = writes;
    tx_data = 8'h7E; tx_valid = 1'b1;
    repeat (60) @(negedge clk);
    check("t4_no_write",  32'(writes - t1),                       32'd0);
    check("t4_repoll",    32'(ctrl_rd - t0 >= 2),                 32'd1);
    check("t4_ctrl_gap",  32'(ctrl_gap >= 18 && ctrl_gap <= 20),  32'd1);
    wspace = 16'd1; n = 0;
    while (!tx_ready && n < 200) begin @(negedge clk); n++; end
    check("t4_tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("t4_writes", 32'(writes - t1),    32'd1);
    check("t4_wdata",  wr_log[$],           32'h7E);
    check("t4_credit", 32'(dut.credit_q),   32'd0);

`ifdef JTAG_UART_BRIDGE_STATS_EN
    check("stat_tx", 32'(tx_byte_cnt), 32'(wr_since_rst));
    check("stat_rx", 32'(rx_byte_cnt), 32'(rx_since_rst));
`else
    check("stat_tx", 32'(tx_byte_cnt), 32'd0);
    check("stat_rx", 32'(rx_byte_cnt), 32'd0);
`endif
    check("bus_excl", 32'(bus_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
